// File: rtl/man_pkg.sv
// Shared definitions for the Manchester encoder/decoder pair: state encodings,
// sync header length and the bit-coding convention.
package man_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC_LO = 3'd1,
        ST_SYNC_HI = 3'd2,
        ST_DATA    = 3'd3,
        ST_PARITY  = 3'd4
    } man_state_e;

    localparam int   MAN_SYNC_HALVES    = 3;
    localparam logic MAN_ONE_FIRST_HALF = 1'b0;

    // Line level for one half of a Manchester bit (IEEE 802.3 polarity).
    function automatic logic man_half_level(input logic b, input logic second_half);
        return (b ? MAN_ONE_FIRST_HALF : ~MAN_ONE_FIRST_HALF) ^ second_half;
    endfunction

endpackage

// File: rtl/man_halfbit_timer.sv
// Half-bit period generator: counts 0..HALF_BIT-1 while run is high and
// pulses tick on the wrap. The count is held at zero while run is low.
module man_halfbit_timer #(
    parameter int HALF_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!run || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/man_tx_encoder.sv
// Manchester frame transmitter: sync header (3 half-bits low, 3 high) then the
// word MSB first. Define MAN_TX_PARITY_EN to append an even-parity bit.
module man_tx_encoder
    import man_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HALF_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              data,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        stat
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    man_state_e        state, state_d;
    logic [1:0]        sync_cnt, sync_d;
    logic              half, half_d;
    logic [BIT_W-1:0]  bit_idx, idx_d;
    logic [DATA_W-1:0] shreg, sh_d;
    logic              line_d;
    logic              done_d;
    logic              tick;
`ifdef MAN_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    man_halfbit_timer #(
        .HALF_BIT (HALF_BIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (state != ST_IDLE),
        .tick (tick)
    );

    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;
    assign stat     = state;

    always_comb begin
        state_d = state;
        sync_d  = sync_cnt;
        half_d  = half;
        idx_d   = bit_idx;
        sh_d    = shreg;
        done_d  = 1'b0;
`ifdef MAN_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SYNC_LO;
                    sh_d    = in_data;
                    idx_d   = BIT_W'(DATA_W);
                    sync_d  = 2'd0;
                    half_d  = 1'b0;
`ifdef MAN_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            ST_SYNC_LO, ST_SYNC_HI: begin
                if (tick) begin
                    if (sync_cnt == 2'(MAN_SYNC_HALVES - 1)) begin
                        sync_d  = 2'd0;
                        half_d  = 1'b0;
                        state_d = (state == ST_SYNC_LO) ? ST_SYNC_HI : ST_DATA;
                    end else begin
                        sync_d = sync_cnt + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (!half) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        sh_d   = shreg << 1;
                        idx_d  = bit_idx - BIT_W'(1);
                        if (bit_idx == BIT_W'(1)) begin
`ifdef MAN_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef MAN_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (!half) begin
                        half_d = 1'b1;
                    end else begin
                        half_d  = 1'b0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // The line is registered from next-state values so it lines up with stat.
    always_comb begin
        line_d = 1'b0;
        case (state_d)
            ST_SYNC_HI: line_d = 1'b1;
            ST_DATA:    line_d = man_half_level(sh_d[DATA_W-1], half_d);
`ifdef MAN_TX_PARITY_EN
            ST_PARITY:  line_d = man_half_level(par_d, half_d);
`endif
            default:    line_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sync_cnt   <= '0;
            half       <= 1'b0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            sync_cnt   <= sync_d;
            half       <= half_d;
            bit_idx    <= idx_d;
            shreg      <= sh_d;
            data       <= line_d;
            frame_done <= done_d;
        end
    end

`ifdef MAN_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_man_tx_encoder.sv
// Directed bench for man_tx_encoder: per-cycle line/state check against an
// expected waveform queue built from the frame format.
module tb_man_tx_encoder;

    localparam int DATA_W   = 8;
    localparam int HALF_BIT = 4;
`ifdef MAN_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int F = 6 * HALF_BIT + 2 * HALF_BIT * (DATA_W + PAR_BITS);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, data, busy, frame_done;
    logic [2:0] stat;

    int n_checks = 0;
    int n_errors = 0;

    // Each entry is {stat, line} for one cycle of the frame.
    logic [3:0] exp_q[$];

    man_tx_encoder #(
        .DATA_W   (DATA_W),
        .HALF_BIT (HALF_BIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data       (data),
        .busy       (busy),
        .frame_done (frame_done),
        .stat       (stat)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b, input logic [2:0] st);
        logic first;
        first = b ? 1'b0 : 1'b1;
        for (int i = 0; i < HALF_BIT; i++) exp_q.push_back({st, first});
        for (int i = 0; i < HALF_BIT; i++) exp_q.push_back({st, ~first});
    endtask

    task automatic push_frame(input logic [7:0] w);
        for (int i = 0; i < 3 * HALF_BIT; i++) exp_q.push_back({3'd1, 1'b0});
        for (int i = 0; i < 3 * HALF_BIT; i++) exp_q.push_back({3'd2, 1'b1});
        for (int b = DATA_W - 1; b >= 0; b--) push_bit(w[b], 3'd3);
`ifdef MAN_TX_PARITY_EN
        push_bit(^w, 3'd4);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  data, 0);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  frame_done, 0);
        check({tag, "_stat"},  stat, 0);
    endtask

    // driver: called at a negedge in an IDLE cycle
    task automatic tx_frame(input logic [7:0] w, input bit keep_valid, input logic [7:0] next_w,
                            input bit holdoff, input int abort_at);
        logic [3:0] e;
        check("ready_idle", in_ready, 1);
        in_data  = w;
        in_valid = 1'b1;
        exp_q.delete();
        push_frame(w);
        @(negedge clk);
        if (keep_valid) begin
            in_data = next_w;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
        end
        for (int c = 1; c <= F; c++) begin
            if (c > 1) @(negedge clk);
            if (abort_at == c) begin
                check("pre_abort_line", data, 1);
                rst = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_q.delete();
                repeat (10) begin
                    @(negedge clk);
                    check_reset_outputs("abort_hold");
                end
                rst = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check_reset_outputs("abort_after");
                end
                return;
            end
            e = exp_q.pop_front();
            check("line", data, e[0]);
            check("stat", stat, e[3:1]);
            check("busy", busy, 1);
            check("ready_busy", in_ready, 0);
            check("done_early", frame_done, 0);
            if (holdoff && c == 20) begin
                in_valid = 1'b1;
                in_data  = 8'h3C;
            end
            if (holdoff && c == 40) in_valid = 1'b0;
        end
        @(negedge clk);
        check("done_pulse", frame_done, 1);
        check("done_line", data, 0);
        check("done_ready", in_ready, 1);
        check("done_stat", stat, 0);
        check("done_busy", busy, 0);
        check("exp_q_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("post_reset");
        end

        tx_frame(8'hA5, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);
        check("done_one_cycle", frame_done, 0);

        tx_frame(8'hFF, 1'b1, 8'h00, 1'b0, 0);
        tx_frame(8'h00, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);

        tx_frame(8'h96, 1'b0, 8'h00, 1'b1, 0);
        @(negedge clk);
        check("holdoff_not_taken", busy, 0);

        tx_frame(8'hA5, 1'b0, 8'h00, 1'b0, 30);
        tx_frame(8'hA5, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);

        tx_frame(8'h07, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);
        tx_frame(8'h03, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/man_tx_encoder.md
# man_tx_encoder

Manchester line encoder that sits directly upstream of the Manchester one-shot decoder FSM and produces its serial `data` input. It accepts a parallel word over a valid/ready handshake and emits one frame on a single serial line. Each frame is a sync header (3 half-bits low, then 3 half-bits high) followed by the word, MSB first, in IEEE 802.3 Manchester coding. The line idles low between frames.

## Interface
Parameters:
- `DATA_W`, 8: payload bits per frame; must be ≥ 1.
- `HALF_BIT`, 4: clock cycles per Manchester half-bit; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_W  word to transmit.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  encoder can accept a word; high only in IDLE.
- `data`  out  1  serial Manchester line, registered.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `stat`  out  3  current FSM state encoding, for debug.

## Operation
- States: IDLE=0, SYNC_LO=1, SYNC_HI=2, DATA=3, PARITY=4 (PARITY exists only with the macro).
- IDLE:
  - `data`=0, `in_ready`=1, `busy`=0.
  - Handshake completes on an edge where `in_valid` && `in_ready`: latch `in_data` into the shift register and go to SYNC_LO.
  - `in_data` is ignored when not handshaking.
- SYNC_LO: `data`=0 for 3·HALF_BIT cycles, then go to SYNC_HI.
- SYNC_HI: `data`=1 for 3·HALF_BIT cycles, then go to DATA.
- DATA: each bit lasts 2·HALF_BIT cycles, MSB first.
  - Bit 1: low for the first half, high for the second half.
  - Bit 0: high for the first half, low for the second half.
  - After bit 0 (the LSB), go to PARITY if enabled, otherwise IDLE.
- Return to IDLE: `frame_done`=1 for exactly that one cycle, and `data`=0.
- `in_ready`=0 and `busy`=1 in every state except IDLE.
- Input is never buffered. A `in_valid` held high across frames is accepted on the first IDLE cycle after `frame_done`.
- Reset mid-frame: output returns immediately to reset values. The frame is abandoned, not resumed, and no `frame_done` is issued.
- Reset values: `data`=0, `in_ready`=1, `busy`=0, `frame_done`=0, `stat`=0. Counters and shift register are cleared to 0.
- Counters:
  - Half-bit counter width is $clog2(HALF_BIT). It wraps HALF_BIT-1 → 0 and produces a tick at the wrap.
  - Sync-half counter counts 0..2.
  - Bit index is $clog2(DATA_W+1) wide and counts down.

## Timing
- Handshake on edge k: `data` and `stat` reflect SYNC_LO from k+1. The first SYNC_HI cycle is k+1+3·HALF_BIT.
- Frame length from k+1 to the last data half-bit: F = 6·HALF_BIT + 2·HALF_BIT·DATA_W cycles, plus 2·HALF_BIT with parity.
- `frame_done` is asserted at cycle k+1+F. `in_ready` is high in that same cycle.
- The earliest next handshake is at edge k+1+F.
- Minimum idle-low gap between frames is 1 cycle. It merges with the next SYNC_LO.
- Defaults (HALF_BIT=4, DATA_W=8): F=88 cycles.

## Configuration
- `MAN_TX_PARITY_EN` defined:
  - After the LSB, the FSM enters PARITY and sends one extra Manchester bit.
  - Its value is the even parity of the word (XOR of all DATA_W bits).
  - `frame_done` follows PARITY; F grows by 2·HALF_BIT.
- `MAN_TX_PARITY_EN` undefined: the PARITY state and its logic are absent, and DATA goes directly to IDLE.

## Structure
- Shared package `man_pkg` holds:
  - the state enum/localparams (IDLE..PARITY);
  - `MAN_SYNC_HALVES`=3;
  - the bit-coding convention constants (`MAN_ONE_FIRST_HALF`=0).
- The decoder uses the same package.
- One sub-module, `man_halfbit_timer`:
  - parameter HALF_BIT; inputs `clk`, `rst`, `run`; output `tick`;
  - the counter clears when `run`=0.
- Implementation size: 150–250 lines of RTL.

## Test plan
- Reset: hold `rst`=0 for 10 cycles mid-stream → `data`=0, `in_ready`=1, `busy`=0, `stat`=0. After release, no spurious `frame_done`.
- Single frame with `in_data`=8'hA5 and defaults → expected line waveform:
  - 12 cycles low, then 12 cycles high;
  - then bits 1,0,1,0,0,1,0,1, each 4 cycles low/high or high/low;
  - `frame_done` 88 cycles after the handshake edge.
- Back-to-back: `in_valid` held high with 8'hFF then 8'h00 → second handshake lands in the `frame_done` cycle. Line shows exactly one low cycle before the second SYNC_LO; the 8'h00 payload is all high-then-low bits.
- Handshake hold-off: assert `in_valid` with a new word while `busy` → `in_ready`=0 and the word is not sampled. The transmitted payload matches the first word.
- Reset at cycle 30 of a frame → `data` goes to 0 asynchronously. A fresh frame started later is bit-exact.
- With `MAN_TX_PARITY_EN`: `in_data`=8'h07 → parity bit 1 is appended; `frame_done` at 96 cycles. `in_data`=8'h03 → parity bit 0.
